// File: rtl/digit_entry_if.sv
// Command/status bundle between the keypad decoder side and the digit entry register.
interface digit_entry_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                   ce;
    logic [WIDTH-1:0]       Din;
    logic                   push;
    logic                   pop;
    logic                   clr;
    logic [WIDTH*DEPTH-1:0] Dout;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   ovf;

    modport master (
        output ce, Din, push, pop, clr,
        input  Dout, count, empty, full, ovf
    );

    modport slave (
        input  ce, Din, push, pop, clr,
        output Dout, count, empty, full, ovf
    );
endinterface

// File: rtl/digit_entry_reg.sv
// Keypad digit accumulator: newest digit in slot 0, with backspace, clear and
// a selectable drop/rolling policy when a digit arrives on a full buffer.
module digit_entry_reg #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned OVF_MODE = 0
) (
    input  logic          CLK,
    input  logic          RST,
    digit_entry_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = WIDTH * DEPTH;

    logic [DW-1:0] dout_q, dout_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, ovf_q, ovf_d;
    logic [DW-1:0] shift_in, shift_out, replace0;
    logic          is_full, is_empty;

    // Slot 0 sits in the low WIDTH bits, so shifting toward older slots moves left.
    assign shift_in  = {dout_q[DW-WIDTH-1:0], bus.Din};
    assign shift_out = {WIDTH'(0), dout_q[DW-1:WIDTH]};
    assign replace0  = {dout_q[DW-1:WIDTH], bus.Din};
    assign is_full   = (count_q == CW'(DEPTH));
    assign is_empty  = (count_q == '0);

    // Command decode, highest priority first; ovf only survives one cycle.
    always_comb begin
        dout_d  = dout_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        if (bus.ce) begin
            if (bus.clr) begin
                dout_d  = '0;
                count_d = '0;
            end else if (bus.push && bus.pop && !is_empty) begin
                dout_d = replace0;
            end else if (bus.push) begin
                if (is_full) begin
                    ovf_d = 1'b1;
                    if (OVF_MODE != 0) begin
                        dout_d = shift_in;
                    end
                end else begin
                    dout_d  = shift_in;
                    count_d = count_q + CW'(1);
                end
            end else if (bus.pop && !is_empty) begin
                dout_d  = shift_out;
                count_d = count_q - CW'(1);
            end
        end
    end

    // Flags are decoded from the next count so they line up with the registered count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.count = count_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_digit_entry_reg.sv
// Directed bench driving a drop-policy and a rolling-policy instance in lockstep.
module tb_digit_entry_reg;
    logic       CLK;
    logic       RST;
    logic       ce, push, pop, clr;
    logic [3:0] din;
    int         total;
    int         bad;

    digit_entry_if #(.WIDTH(4), .DEPTH(4)) b0 ();
    digit_entry_if #(.WIDTH(4), .DEPTH(4)) b1 ();

    assign b0.ce = ce;  assign b0.push = push; assign b0.pop = pop;
    assign b0.clr = clr; assign b0.Din = din;
    assign b1.ce = ce;  assign b1.push = push; assign b1.pop = pop;
    assign b1.clr = clr; assign b1.Din = din;

    digit_entry_reg #(.WIDTH(4), .DEPTH(4), .OVF_MODE(0)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
    digit_entry_reg #(.WIDTH(4), .DEPTH(4), .OVF_MODE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one command for one clock, then sample just after the edge.
    task automatic cmd(input logic c, input logic p, input logic q, input logic k, input logic [3:0] d);
        ce = c; push = p; pop = q; clr = k; din = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [2:0] c, input logic e, input logic f, input logic o);
        check({tag, ".dout0"}, 64'(b0.Dout), 64'(d0));
        check({tag, ".dout1"}, 64'(b1.Dout), 64'(d1));
        check({tag, ".count0"}, 64'(b0.count), 64'(c));
        check({tag, ".count1"}, 64'(b1.count), 64'(c));
        check({tag, ".empty"}, 64'({b0.empty, b1.empty}), 64'({e, e}));
        check({tag, ".full"}, 64'({b0.full, b1.full}), 64'({f, f}));
        check({tag, ".ovf"}, 64'({b0.ovf, b1.ovf}), 64'({o, o}));
        check({tag, ".inv"}, 64'({b0.empty & b0.full, b1.empty & b1.full}), 64'(0));
    endtask

    initial begin
        total = 0; bad = 0;
        RST = 1'b1; ce = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
        cmd(0, 0, 0, 0, 4'h0);
        expect_all("reset", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);
        RST = 1'b0;

        cmd(1, 1, 0, 0, 4'h1); expect_all("push1", 16'h0001, 16'h0001, 3'd1, 0, 0, 0);
        cmd(1, 1, 0, 0, 4'h2); expect_all("push2", 16'h0012, 16'h0012, 3'd2, 0, 0, 0);
        cmd(1, 1, 0, 0, 4'h3); expect_all("push3", 16'h0123, 16'h0123, 3'd3, 0, 0, 0);
        cmd(1, 1, 0, 0, 4'h4); expect_all("push4", 16'h1234, 16'h1234, 3'd4, 0, 1, 0);
        cmd(1, 1, 0, 0, 4'h5); expect_all("ovf5", 16'h1234, 16'h2345, 3'd4, 0, 1, 1);
        cmd(1, 0, 0, 0, 4'h0); expect_all("ovfend", 16'h1234, 16'h2345, 3'd4, 0, 1, 0);
        cmd(1, 1, 0, 0, 4'h6); expect_all("ovf6", 16'h1234, 16'h3456, 3'd4, 0, 1, 1);
        cmd(1, 1, 1, 0, 4'h8); expect_all("repfull", 16'h1238, 16'h3458, 3'd4, 0, 1, 0);

        cmd(1, 0, 0, 1, 4'h0); expect_all("clr", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);
        cmd(1, 1, 0, 0, 4'h1);
        cmd(1, 1, 0, 0, 4'h2);
        cmd(1, 1, 0, 0, 4'h3); expect_all("refill", 16'h0123, 16'h0123, 3'd3, 0, 0, 0);
        cmd(1, 0, 1, 0, 4'hA); expect_all("pop1", 16'h0012, 16'h0012, 3'd2, 0, 0, 0);
        cmd(1, 1, 1, 0, 4'h7); expect_all("rep7", 16'h0017, 16'h0017, 3'd2, 0, 0, 0);
        cmd(1, 0, 1, 0, 4'h0); expect_all("pop2", 16'h0001, 16'h0001, 3'd1, 0, 0, 0);
        cmd(1, 0, 1, 0, 4'h0); expect_all("pop3", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);
        cmd(1, 0, 1, 0, 4'h0); expect_all("popempty", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);
        cmd(1, 1, 1, 0, 4'h9); expect_all("repempty", 16'h0009, 16'h0009, 3'd1, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            cmd(0, i[0], i[1], (i == 2), 4'hF);
            expect_all("cehold", 16'h0009, 16'h0009, 3'd1, 0, 0, 0);
        end
        cmd(1, 0, 0, 1, 4'h0); expect_all("ceclr", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);

        cmd(1, 1, 0, 0, 4'h1);
        cmd(1, 1, 0, 0, 4'h2);
        cmd(1, 1, 0, 0, 4'h3); expect_all("pre_rst", 16'h0123, 16'h0123, 3'd3, 0, 0, 0);
        RST = 1'b1;
        cmd(1, 1, 0, 0, 4'h4); expect_all("rstpush", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);
        RST = 1'b0;
        cmd(1, 1, 0, 0, 4'h1);
        cmd(1, 1, 0, 0, 4'h2); expect_all("pre_clr", 16'h0012, 16'h0012, 3'd2, 0, 0, 0);
        cmd(1, 1, 0, 1, 4'h5); expect_all("clrpush", 16'h0000, 16'h0000, 3'd0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/digit_entry_reg.md
# digit_entry_reg

Parametrised keypad digit entry register for the door-lock datapath. It sits between the keypad decoder and the password comparator. It accumulates WIDTH-bit digit codes into a DEPTH-slot buffer, newest digit in slot 0, and supports a clock enable, backspace, clear and a selectable overflow policy. The concatenated buffer, digit count and status flags are all registered outputs.

## Interface
Parameters:
- WIDTH, 4, bits per digit code
- DEPTH, 4, number of digit slots (≥2)
- OVF_MODE, 0, push-when-full policy: 0 = drop new digit; 1 = rolling window, oldest digit discarded

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low, all state holds (RST still acts)
- Din  in  WIDTH  digit code to insert
- push  in  1  insert Din as newest digit
- pop  in  1  backspace: remove newest digit
- clr  in  1  synchronous clear of buffer and count
- Dout  out  WIDTH*DEPTH  slots concatenated {slot[DEPTH-1], …, slot[0]}
- count  out  $clog2(DEPTH+1)  number of valid digits, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  one-cycle pulse: push attempted while full

## Operation
- Reset (RST=1 at CLK edge):
  - all slots = 0, count = 0
  - empty = 1, full = 0, ovf = 0
  - RST overrides ce and every command.
- When ce = 0: slots, count and flags hold; ovf = 0.
- When ce = 1, command priority per cycle:
  1. clr: slots = 0, count = 0, ovf = 0.
  2. push & pop together ("replace"):
     - count > 0: slot[0] = Din, count unchanged.
     - count == 0: behaves as push.
  3. push, not full: slot[i] = slot[i-1] for i ≥ 1, slot[0] = Din, count + 1.
  4. push, full:
     - OVF_MODE=0: no state change, ovf = 1.
     - OVF_MODE=1: shift as in 3, old slot[DEPTH-1] discarded, count stays DEPTH, ovf = 1.
  5. pop, count > 0: slot[i] = slot[i+1], slot[DEPTH-1] = 0, count − 1.
  6. pop, empty: no change, no error flag.
- Slot invariant: slots at index ≥ count always read 0. The verifier checks this every cycle.
- Flag rules:
  - empty and full are decoded from the registered count; both are never high together.
  - ovf is high only in the cycle after an offending push; otherwise 0.
- Din is sampled only on push; its value is don't-care otherwise.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency of 1 CLK: a command sampled at edge k is visible on Dout/count/flags after edge k.
- Back-to-back commands are accepted every cycle at full rate; there is no busy state.
- Reset or clr mid-entry takes effect at the same edge and discards the partial entry. A push in the same cycle as clr is lost.
- ce low for any number of cycles, then high, resumes with state intact.

## Test plan
- Reset then push 1,2,3 (ce=1, WIDTH=4, DEPTH=4) -> Dout=16'h0123, count=3, empty=0, full=0.
- Push 1,2,3,4, then push 5:
  - OVF_MODE=0 -> Dout=16'h1234, count=4, full=1, ovf pulses one cycle.
  - OVF_MODE=1 -> Dout=16'h2345, count=4, ovf pulses.
- From 16'h0123: pop -> Dout=16'h0012, count=2; pop ×3 more -> Dout=0, count=0, empty=1, ovf never asserted.
- From 16'h0012: push&pop with Din=7 -> Dout=16'h0017, count=2. On empty, push&pop with Din=9 -> Dout=16'h0009, count=1.
- Hold ce=0 while toggling push/pop/clr with Din=F for 5 cycles -> outputs unchanged. Then ce=1, clr -> Dout=0, count=0.
- Assert RST in the same cycle as push while count=3 -> next cycle all outputs at reset values. Assert clr+push together -> count=0, Dout=0.
